// File: rtl/fifo_ui_pkg.sv
// Shared types and default board timing for the FIFO controller front end.
package fifo_ui_pkg;

  typedef enum logic [2:0] {
    RELEASED   = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    LOCKED     = 3'd4,
    RELEASE_DB = 3'd5
  } btn_state_t;

  // 50 MHz board: 10 ms debounce, 0.5 s to first repeat, 0.2 s repeat period
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;
  localparam int unsigned DEF_CNT_W           = 25;
  localparam bit          DEF_REPEAT_EN       = 1'b1;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer, and a synchronizer followed by a stable-level
// debounce counter that only accepts a level held for DEBOUNCE_CYCLES cycles.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Metastability filter; both stages reset to the idle level of the input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 25,
  parameter logic        RST_VAL         = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_change
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync;
  logic             w_diff;
  logic             w_expire;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  sync_2ff #(.RST_VAL(RST_VAL)) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_async),
    .o_sync  (w_sync)
  );

  assign w_diff   = (w_sync != r_level);
  // High on the edge where the new level is accepted, so consumers can act
  // on the change in the same cycle the level register updates.
  assign w_expire = w_diff && (r_cnt == DB_LAST);

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= RST_VAL;
    end else if (!w_diff) begin
      r_cnt   <= '0;
    end else if (w_expire) begin
      r_cnt   <= '0;
      r_level <= w_sync;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_level  = r_level;
  assign o_change = w_expire;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw pushbutton and mode switch into a single-cycle button
// pulse (with optional auto-repeat), a debounced held level and a debounced mode.
module button_conditioner
  import fifo_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clock,
  input  logic rstsync,
  input  logic button_n_raw,
  input  logic mode_raw,
  output logic button,
  output logic mode,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             w_bsync_n;
  logic             w_bsync;
  logic             w_mode;
  logic             w_mode_toggle;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_button;
  logic             r_pressed;

  // Button: synchronizer only; idle level is released (high, active-low key).
  sync_2ff #(.RST_VAL(1'b1)) u_btn_sync (
    .i_clk   (clock),
    .i_rst   (rstsync),
    .i_async (button_n_raw),
    .o_sync  (w_bsync_n)
  );

  assign w_bsync = ~w_bsync_n;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .RST_VAL         (1'b0)
  ) u_mode_db (
    .i_clk    (clock),
    .i_rst    (rstsync),
    .i_async  (mode_raw),
    .o_level  (w_mode),
    .o_change (w_mode_toggle)
  );

  // Button FSM: debounce press/release, emit press and repeat pulses, and
  // lock out further pulses once the mode flips under a held key.
  always_ff @(posedge clock) begin
    if (rstsync) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_button  <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_button <= 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_bsync) begin
            r_state <= PRESS_DB;
            r_cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (!w_bsync) begin
            r_state <= RELEASED;
          end else if (r_cnt == DB_LAST) begin
            r_state   <= HELD;
            r_cnt     <= '0;
            r_button  <= 1'b1;
            r_pressed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HELD: begin
          // Release outranks a mode flip, which outranks a repeat expiry.
          if (!w_bsync) begin
            r_state   <= RELEASE_DB;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
          end else if (w_mode_toggle) begin
            r_state <= LOCKED;
          end else if (REPEAT_EN && (r_cnt == DLY_LAST)) begin
            r_state  <= REPEAT;
            r_cnt    <= '0;
            r_button <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!w_bsync) begin
            r_state   <= RELEASE_DB;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
          end else if (w_mode_toggle) begin
            r_state <= LOCKED;
          end else if (r_cnt == PER_LAST) begin
            r_cnt    <= '0;
            r_button <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!w_bsync) begin
            r_state   <= RELEASE_DB;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
          end
        end
        RELEASE_DB: begin
          if (w_bsync) begin
            r_state   <= HELD;
            r_cnt     <= '0;
            r_pressed <= 1'b1;
          end else if (r_cnt == DB_LAST) begin
            r_state <= RELEASED;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= RELEASED;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
        end
      endcase
    end
  end

  assign button  = r_button;
  assign mode    = w_mode;
  assign pressed = r_pressed;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a run-length
// reference model of the debounce, repeat and lock rules.
module tb_button_conditioner;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 3;

  logic clock = 1'b0;
  logic rstsync;
  logic button_n_raw;
  logic mode_raw;
  logic button;
  logic mode;
  logic pressed;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (8)
  ) dut (
    .clock        (clock),
    .rstsync      (rstsync),
    .button_n_raw (button_n_raw),
    .mode_raw     (mode_raw),
    .button       (button),
    .mode         (mode),
    .pressed      (pressed)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_log[$];

  // Reference model: raw inputs reach the decision logic two edges late;
  // the rest is expressed as run lengths of the seen levels.
  logic dp0 = 1'b1, dp1 = 1'b1, dm0 = 1'b0, dm1 = 1'b0;
  bit   m_held = 0, m_locked = 0, m_first = 0, m_mode = 0;
  int   m_prun = 0, m_relrun = 0, m_since = 0, m_mrun = 0;
  bit   e_button = 0;

  task automatic model_edge(input logic b, input logic m, input logic r);
    bit p, ms, tog;
    e_button = 0;
    if (r) begin
      dp0 = 1'b1; dp1 = 1'b1; dm0 = 1'b0; dm1 = 1'b0;
      m_held = 0; m_locked = 0; m_first = 0; m_mode = 0;
      m_prun = 0; m_relrun = 0; m_since = 0; m_mrun = 0;
      return;
    end
    p  = ~dp1;
    ms = dm1;
    dp1 = dp0; dp0 = b;
    dm1 = dm0; dm0 = m;
    tog = 0;
    if (ms != m_mode) begin
      m_mrun++;
      if (m_mrun == int'(D)) begin
        m_mode = ms; m_mrun = 0; tog = 1;
      end
    end else begin
      m_mrun = 0;
    end
    if (!m_held) begin
      if (p) begin
        m_prun++;
        if (m_prun == int'(D) + 1) begin
          m_held = 1; m_relrun = 0; m_since = 0; m_first = 1; m_locked = 0;
          e_button = 1;
        end
      end else begin
        m_prun = 0;
      end
    end else begin
      if (!p) begin
        m_relrun++;
        if (m_relrun == int'(D) + 1) begin
          m_held = 0; m_prun = 0;
        end
      end else if (m_relrun > 0) begin
        m_relrun = 0; m_since = 0; m_first = 1; m_locked = 0;
      end else if (tog) begin
        m_locked = 1;
      end else if (!m_locked) begin
        m_since++;
        if (m_since == (m_first ? int'(RD) : int'(RP))) begin
          e_button = 1; m_since = 0; m_first = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(input logic b, input logic m, input logic r);
    button_n_raw = b;
    mode_raw     = m;
    rstsync      = r;
    @(posedge clock);
    cyc++;
    model_edge(b, m, r);
    #1;
    if (button === 1'b1) pulse_log.push_back(cyc);
    chk("button",  button,  e_button);
    chk("pressed", pressed, m_held && (m_relrun == 0));
    chk("mode",    mode,    m_mode);
  endtask

  task automatic ticks(input int n, input logic b, input logic m);
    for (int i = 0; i < n; i++) tick(b, m, 1'b0);
  endtask

  int t0;
  logic rb, rm, rr;
  int bseg, mseg;

  initial begin
    rstsync = 1'b1; button_n_raw = 1'b1; mode_raw = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
    chk("rst_button",  button,  1'b0);
    chk("rst_mode",    mode,    1'b0);
    chk("rst_pressed", pressed, 1'b0);
    ticks(5, 1'b1, 1'b0);

    // Clean press: low for 5 samples, pulse exactly 6 edges after first low sample.
    pulse_log.delete();
    t0 = cyc + 1;
    ticks(5, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0);
    chk_int("clean_count", pulse_log.size(), 1);
    if (pulse_log.size() > 0) chk_int("clean_latency", pulse_log[0] - t0, 6);

    // Bounce: 3 low, 1 high, 2 low never reaches a full debounce.
    pulse_log.delete();
    ticks(3, 1'b0, 1'b0);
    ticks(1, 1'b1, 1'b0);
    ticks(2, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0);
    chk_int("bounce_count", pulse_log.size(), 0);

    // Auto-repeat: first repeat 8 after the press pulse, then every 3.
    pulse_log.delete();
    t0 = cyc + 1;
    ticks(36, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0);
    chk_int("repeat_count", pulse_log.size(), 9);
    if (pulse_log.size() >= 3) begin
      chk_int("repeat_first", pulse_log[0] - t0, 6);
      chk_int("repeat_delay", pulse_log[1] - pulse_log[0], 8);
      chk_int("repeat_period", pulse_log[2] - pulse_log[1], 3);
    end

    // Release bounce: 2-cycle release returns to HELD and restarts the delay.
    pulse_log.delete();
    t0 = cyc + 1;
    ticks(8, 1'b0, 1'b0);
    ticks(2, 1'b1, 1'b0);
    ticks(20, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0);
    chk_int("relbounce_count", pulse_log.size(), 5);
    if (pulse_log.size() >= 2) chk_int("relbounce_next", pulse_log[1] - t0, 20);

    // Mode flips while held: mode rises 15 edges in, then the key is locked.
    pulse_log.delete();
    t0 = cyc + 1;
    ticks(10, 1'b0, 1'b0);
    ticks(10, 1'b0, 1'b1);
    chk("locked_mode", mode, 1'b1);
    chk("locked_pressed", pressed, 1'b1);
    ticks(10, 1'b1, 1'b1);
    chk_int("locked_count", pulse_log.size(), 2);
    pulse_log.delete();
    ticks(8, 1'b0, 1'b1);
    ticks(10, 1'b1, 1'b1);
    chk_int("repress_count", pulse_log.size(), 1);

    // Reset mid-debounce with the key held and mode switch high.
    pulse_log.delete();
    t0 = cyc + 1;
    ticks(3, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("midrst_mode", mode, 1'b0);
    ticks(12, 1'b0, 1'b1);
    ticks(10, 1'b1, 1'b1);
    chk_int("midrst_count", pulse_log.size(), 1);
    if (pulse_log.size() > 0) chk_int("midrst_latency", pulse_log[0] - t0, 10);

    // Random bouncy key and switch activity with occasional resets.
    bseg = 0; mseg = 0; rb = 1'b1; rm = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (bseg == 0) begin
        rb   = 1'($urandom_range(0, 1));
        bseg = $urandom_range(1, 40);
      end
      if (mseg == 0) begin
        rm   = 1'($urandom_range(0, 1));
        mseg = $urandom_range(1, 30);
      end
      rr = ($urandom_range(0, 499) == 0);
      tick(rb, rm, rr);
      bseg--;
      mseg--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end input stage for the FIFO read/write controller. It conditions the raw pushbutton and the raw mode slide switch and produces the `button` and `mode` inputs that the controller FSM consumes.
- Raw inputs pass through a 2-flop synchronizer and a debounce counter.
- A debounced press yields exactly one single-cycle `button` pulse.
- An optional auto-repeat emits further pulses while the button is held, so the FIFO can be filled or drained by holding the key.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 2
REPEAT_EN, 1, 1 enables auto-repeat while held; 0 gives one pulse per press
REPEAT_DELAY, 25000000, cycles from the first pulse to the first repeat pulse
REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses
CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
clock  input  1  system clock; all logic on the rising edge
rstsync  input  1  reset, synchronous, active-high
button_n_raw  input  1  raw pushbutton, active-low, asynchronous, bouncy
mode_raw  input  1  raw slide switch (0 = read, 1 = write), asynchronous
button  output  1  registered one-cycle pulse per accepted press or repeat
mode  output  1  debounced, registered mode level
pressed  output  1  debounced held level (1 while in HELD, REPEAT or LOCKED)

Behaviour:
- Reset (rstsync = 1 at a clock edge):
  - Synchronizers load "released" (1) for the button and 0 for mode.
  - State = RELEASED; counters = 0.
  - button = 0, mode = 0, pressed = 0.
  - Reset mid-press discards all progress; no pulse follows reset even if the key is still held, until the full debounce completes again.
- Synchronizer: 2 flops per raw input. The FSM uses only the 2nd flop, `bsync`, where bsync = 1 means pressed after inversion.
- Button FSM states: RELEASED, PRESS_DB, HELD, REPEAT, LOCKED, RELEASE_DB. `cnt` is shared.
  - RELEASED: bsync = 1 -> PRESS_DB, cnt = 0.
  - PRESS_DB:
    - bsync = 0 -> RELEASED (bounce rejected, no pulse).
    - cnt == DEBOUNCE_CYCLES-1 -> HELD, cnt = 0, button = 1 next cycle.
    - Otherwise cnt + 1.
  - HELD:
    - bsync = 0 -> RELEASE_DB, cnt = 0.
    - REPEAT_EN and cnt == REPEAT_DELAY-1 -> REPEAT, cnt = 0, pulse.
    - Otherwise cnt + 1. With REPEAT_EN = 0, cnt saturates and no pulse is emitted.
  - REPEAT:
    - bsync = 0 -> RELEASE_DB, cnt = 0.
    - cnt == REPEAT_PERIOD-1 -> pulse, cnt = 0.
    - Otherwise cnt + 1.
  - LOCKED: entered from HELD/REPEAT when the debounced mode toggles. No pulses. bsync = 0 -> RELEASE_DB, cnt = 0.
  - RELEASE_DB:
    - bsync = 1 -> HELD, cnt = 0, no pulse (release bounce rejected).
    - cnt == DEBOUNCE_CYCLES-1 -> RELEASED.
    - Otherwise cnt + 1.
  - Any unused encoding -> RELEASED.
- Latency:
  - Let edge k be the first edge that samples button_n_raw = 0, with the input stable thereafter.
  - button is high for exactly the one cycle following edge k+2+DEBOUNCE_CYCLES.
  - A pulse is always exactly 1 cycle wide; two pulses are never adjacent.
- Mode debounce:
  - Independent counter. While msync != mode it counts; msync == mode clears it.
  - When the count reaches DEBOUNCE_CYCLES-1, mode <= msync and the counter clears.
  - mode changes at most once per DEBOUNCE_CYCLES cycles.
- Simultaneous events:
  - If the mode toggle and a repeat expiry fall on the same edge, the mode change wins: the state goes to LOCKED and no pulse is emitted.
  - Mode changes while RELEASED or PRESS_DB do not affect the button FSM.
- Counters never wrap: each counter compares for equality and is cleared on the same edge.

Decomposition:
- Package fifo_ui_pkg:
  - typedef enum logic [2:0] btn_state_t {RELEASED, PRESS_DB, HELD, REPEAT, LOCKED, RELEASE_DB}.
  - Default timing constants for the 50 MHz board.
- Sub-module sync_debounce (2-flop synchronizer plus stable-level counter, params DEBOUNCE_CYCLES, CNT_W, RST_VAL):
  - Used for the mode path.
  - The button path reuses only its synchronizer half; the FSM owns the button counter.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, REPEAT_EN=1):
- Clean press: button_n_raw 1->0 sampled at edge 10, held 5 cycles, then released -> one button pulse in the cycle after edge 16; pressed = 1 from edge 16.
- Bounce: button_n_raw low 3 cycles, high 1, low 2, then high -> zero pulses; state returns to RELEASED.
- Auto-repeat: hold 30 cycles from first pulse at edge 16 -> pulses after edges 16, 24, 27, 30, 33, ...; release -> pulses stop; RELEASED after 4 stable high cycles.
- Release bounce: after a pulse, release for 2 cycles then re-press -> no new pulse; HELD with cnt restarted; the next repeat comes 8 cycles later.
- Mode toggle while held: mode_raw 0->1 at edge 20 -> mode = 1 after edge 25; state LOCKED; no further pulses until release plus re-press.
- Reset mid-debounce: rstsync = 1 at edge 13 during PRESS_DB with the key held -> button = 0, mode = 0; the first pulse occurs only after the full 4-cycle debounce after reset deasserts.
